// File: rtl/ascii_num_parser.sv
// rtl/ascii_num_parser.sv - streaming ASCII decimal parser.
// Accumulates digit runs into a saturating unsigned value; one result per run on its terminator.
module ascii_num_parser #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] value,
  output logic [7:0]       ndigits,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [7:0]       cnt, cnt_next;
  logic             ovf, ovf_next;
  logic             load;
  logic             is_digit;
  logic [3:0]       digit;
  logic [WIDTH+3:0] prod;
  logic             in_xfer;

  // For codes 0x30..0x39 the low nibble is the digit value.
  assign is_digit = (code >= 7'h30) && (code <= 7'h39);
  assign digit    = code[3:0];
  assign prod     = {4'b0000, acc} * (WIDTH+4)'(10) + (WIDTH+4)'(digit);
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;
    load       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_xfer && is_digit) begin
          acc_next   = WIDTH'(digit);
          cnt_next   = 8'd1;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = !rst;
        if (in_xfer) begin
          if (is_digit) begin
            cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            // Once saturated the accumulator is pinned at all-ones.
            if (ovf || (prod[WIDTH+3:WIDTH] != 4'b0000)) begin
              acc_next = '1;
              ovf_next = 1'b1;
            end else begin
              acc_next = prod[WIDTH-1:0];
            end
          end else begin
            load       = 1'b1;
            state_next = EMIT;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value    <= '0;
      ndigits  <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      value    <= acc;
      ndigits  <= cnt;
      overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_ascii_num_parser.sv
// tb/tb_ascii_num_parser.sv - randomized self-checking bench for ascii_num_parser.
// Reference model parses the consumed character stream with plain integer arithmetic.
module tb_ascii_num_parser;

  localparam int W = 16;
  localparam longint MAXV = (longint'(1) << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [6:0]   code = 7'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] value;
  logic [7:0]   ndigits;
  logic         overflow;
  logic         out_valid;
  logic         out_ready = 1'b0;

  ascii_num_parser #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .code(code), .in_valid(in_valid), .in_ready(in_ready),
    .value(value), .ndigits(ndigits), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint v;
    int     n;
    bit     o;
  } res_t;

  int     vectors = 0;
  int     miscompares = 0;
  byte    char_q[$];
  res_t   exp_q[$];
  res_t   last;
  bit     m_inrun = 0;
  bit     m_pending = 0;
  longint m_v = 0;
  int     m_n = 0;
  bit     m_o = 0;
  bit     waiting = 0;
  int     stall_left = 0;
  int     gap_mode = 0;
  int     rnd_ready = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inrun = 0; m_pending = 0; m_v = 0; m_n = 0; m_o = 0;
    last.v = 0; last.n = 0; last.o = 0;
    exp_q.delete();
    char_q.delete();
    waiting = 0;
  endtask

  task automatic model_char(input byte c);
    res_t r;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (!m_inrun) begin
        m_inrun = 1; m_v = c - 8'h30; m_n = 1; m_o = 0;
      end else begin
        m_v = m_v * 10 + (c - 8'h30);
        if (m_v > MAXV) begin m_v = MAXV; m_o = 1; end
        if (m_n < 255) m_n++;
      end
    end else if (m_inrun) begin
      r.v = m_v; r.n = m_n; r.o = m_o;
      exp_q.push_back(r);
      m_inrun = 0;
      m_pending = 1;
    end
  endtask

  task automatic step();
    res_t e;
    byte  c;
    bit   xfer_in, xfer_out;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(!m_pending));
    check("out_valid", 32'(out_valid), 32'(m_pending));
    e = m_pending ? exp_q[0] : last;
    check("value", 32'(value), 32'(e.v));
    check("ndigits", 32'(ndigits), 32'(e.n));
    check("overflow", 32'(overflow), 32'(e.o));
    if (stall_left > 0 && m_pending) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (char_q.size() == 0) begin
      in_valid = 1'b0;
    end else begin
      c = char_q[0];
      code = c[6:0];
      if (!waiting) in_valid = gap_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
    end
    xfer_in  = in_valid && !m_pending;
    xfer_out = m_pending && out_ready;
    waiting  = in_valid && !xfer_in;
    if (xfer_out) begin
      last = exp_q.pop_front();
      m_pending = 0;
    end
    if (xfer_in) model_char(char_q.pop_front());
  endtask

  task automatic push_str(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      char_q.push_back(b);
    end
  endtask

  task automatic run(input int gap, input int rr);
    int budget;
    gap_mode = gap;
    rnd_ready = rr;
    budget = 0;
    while ((char_q.size() > 0 || m_pending) && budget < 5000) begin
      step();
      budget++;
    end
    if (budget >= 5000) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_value"}, 32'(value), 32'd0);
    check({tag, "_ndigits"}, 32'(ndigits), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic add_random(input int len);
    int  r;
    byte b;
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       b = byte'(8'h30 + $urandom_range(0, 9));
      else if (r == 6) b = 8'h20;
      else if (r == 7) b = byte'($urandom_range(0, 127));
      else if (r == 8) b = ($urandom_range(0, 1) != 0) ? 8'h2F : 8'h3A;
      else             b = 8'h2D;
      char_q.push_back(b);
    end
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    push_str("123 ");        run(0, 0);
    push_str("65535,");      run(0, 0);
    push_str("65536;");      run(0, 0);
    push_str("ab-007\n");    run(0, 0);
    stall_left = 10;
    push_str("42 9 ");       run(0, 0);

    push_str("12");          run(0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1 check_reset_outputs("mid");
    @(negedge clk);
    check_reset_outputs("mid_hold");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    push_str("3 ");          run(0, 0);

    for (int i = 0; i < 300; i++) char_q.push_back(8'h39);
    char_q.push_back(8'h2E);
    run(0, 0);

    for (int k = 0; k < 40; k++) begin
      add_random(20);
      char_q.push_back(8'h20);
      run(1, 1);
    end
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
